// File: rtl/seq_approx_mult8x8.sv
// Sequential 8x8 unsigned multiplier sharing one external 4x4 unit over four nibble steps.
// States: IDLE waits for start | MUL issues one nibble pair per cycle | DONE pulses done for one cycle.
module seq_approx_mult8x8 #(
    parameter bit TRUNC_LL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [3:0]  o_mul_a,
    output logic [3:0]  o_mul_b,
    input  logic [7:0]  i_mul_p,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [16:0] r_acc;
    logic [15:0] r_p;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  w_mul_a;
    logic [3:0]  w_mul_b;
    logic [3:0]  w_shift;
    logic [16:0] w_term;
    logic [16:0] w_sum;

    always_comb begin
        w_next  = r_state;
        w_mul_a = 4'd0;
        w_mul_b = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_MUL;
            end
            S_MUL: begin
                w_mul_a = r_step[1] ? r_a[7:4] : r_a[3:0];
                w_mul_b = r_step[0] ? r_b[7:4] : r_b[3:0];
                if (r_step == 2'd3) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Step 0 is unshifted, the two cross terms sit at 4, the high term at 8.
    always_comb begin
        case (r_step)
            2'd0:    w_shift = 4'd0;
            2'd3:    w_shift = 4'd8;
            default: w_shift = 4'd4;
        endcase
        w_term = {9'd0, i_mul_p} << w_shift;
        w_sum  = r_acc + w_term;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_step  <= 2'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_acc   <= 17'd0;
            r_p     <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a    <= i_a;
                        r_b    <= i_b;
                        r_acc  <= 17'd0;
                        r_step <= TRUNC_LL ? 2'd1 : 2'd0;
                    end
                end
                S_MUL: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    // An approximate 4x4 unit can push the sum past 16 bits.
                    if (r_step == 2'd3) r_p <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
                end
                default: ;
            endcase
        end
    end

    assign o_mul_a = w_mul_a;
    assign o_mul_b = w_mul_b;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_p     = r_p;

endmodule

// File: tb/tb_seq_approx_mult8x8.sv
// Randomized and directed checks of seq_approx_mult8x8 in both full and TRUNC_LL modes.
module tb_seq_approx_mult8x8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s0, s1, sat0, sat1;
    logic [7:0]  a0, b0, a1, b1;
    logic [3:0]  ma0, mb0, ma1, mb1;
    logic [7:0]  mp0, mp1;
    logic        bz0, bz1, dn0, dn1;
    logic [15:0] p0, p1;

    int n_total = 0;
    int n_bad   = 0;

    // 4x4 unit model: exact product, or a saturating approximation returning 0xFF.
    assign mp0 = sat0 ? 8'hFF : ({4'd0, ma0} * {4'd0, mb0});
    assign mp1 = sat1 ? 8'hFF : ({4'd0, ma1} * {4'd0, mb1});

    seq_approx_mult8x8 #(.TRUNC_LL(1'b0)) u_full (
        .i_clk(clk), .i_rst(rst), .i_start(s0), .i_a(a0), .i_b(b0),
        .o_mul_a(ma0), .o_mul_b(mb0), .i_mul_p(mp0),
        .o_busy(bz0), .o_done(dn0), .o_p(p0)
    );

    seq_approx_mult8x8 #(.TRUNC_LL(1'b1)) u_trunc (
        .i_clk(clk), .i_rst(rst), .i_start(s1), .i_a(a1), .i_b(b1),
        .o_mul_a(ma1), .o_mul_b(mb1), .i_mul_p(mp1),
        .o_busy(bz1), .o_done(dn1), .o_p(p1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_p(input logic [7:0] av, input logic [7:0] bv,
                                          input bit trunc, input bit sat);
        int tot;
        if (sat) tot = 255 * ((trunc ? 0 : 1) + 16 + 16 + 256);
        else     tot = int'(av) * int'(bv) - (trunc ? int'(av[3:0]) * int'(bv[3:0]) : 0);
        return (tot > 65535) ? 32'd65535 : 32'(tot);
    endfunction

    task automatic drive_in(input int t, input logic s, input logic [7:0] av,
                            input logic [7:0] bv, input logic st);
        if (t == 0) begin s0 = s; a0 = av; b0 = bv; sat0 = st; end
        else        begin s1 = s; a1 = av; b1 = bv; sat1 = st; end
    endtask

    function automatic logic get_done(input int t);
        return (t == 0) ? dn0 : dn1;
    endfunction
    function automatic logic get_busy(input int t);
        return (t == 0) ? bz0 : bz1;
    endfunction
    function automatic logic [15:0] get_p(input int t);
        return (t == 0) ? p0 : p1;
    endfunction
    function automatic logic [7:0] get_pair(input int t);
        return (t == 0) ? {ma0, mb0} : {ma1, mb1};
    endfunction

    // Call just after a negedge. Checks nibble pairs, latency, result and return to idle.
    task automatic run_op(input int t, input logic [7:0] av, input logic [7:0] bv,
                          input bit sat, input bit poke, input string tag);
        bit          trunc;
        int          nsteps, cyc, npairs, s, extra;
        bit          seen;
        logic [3:0]  ea, eb;
        trunc  = (t == 1);
        nsteps = trunc ? 3 : 4;
        drive_in(t, 1'b1, av, bv, sat);
        @(posedge clk);
        #1 drive_in(t, 1'b0, 8'($urandom), 8'($urandom), sat);
        cyc = 0; npairs = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (get_done(t)) seen = 1;
            else begin
                if (npairs < nsteps) begin
                    s  = trunc ? npairs + 1 : npairs;
                    ea = (s >= 2) ? av[7:4] : av[3:0];
                    eb = (s % 2 == 1) ? bv[7:4] : bv[3:0];
                    chk({tag, "_pair"}, 32'(get_pair(t)), {24'd0, ea, eb});
                end
                npairs++;
                if (poke && cyc == 2) drive_in(t, 1'b1, ~av, ~bv, sat);
                if (poke && cyc == 3) drive_in(t, 1'b0, 8'($urandom), 8'($urandom), sat);
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({tag, "_lat"}, 32'(cyc), trunc ? 32'd4 : 32'd5);
            chk({tag, "_p"}, 32'(get_p(t)), ref_p(av, bv, trunc, sat));
            chk({tag, "_nsteps"}, 32'(npairs), 32'(nsteps));
            chk({tag, "_pairdone"}, 32'(get_pair(t)), 32'd0);
        end
        if (poke) drive_in(t, 1'b1, ~av, bv, sat);
        @(negedge clk);
        if (poke) drive_in(t, 1'b0, 8'd0, 8'd0, sat);
        chk({tag, "_busy_after"}, 32'(get_busy(t)), 32'd0);
        chk({tag, "_done_after"}, 32'(get_done(t)), 32'd0);
        if (poke) begin
            extra = 0;
            repeat (8) begin
                @(negedge clk);
                if (get_done(t) || get_busy(t)) extra++;
            end
            chk({tag, "_no_extra"}, 32'(extra), 32'd0);
            chk({tag, "_p_hold"}, 32'(get_p(t)), ref_p(av, bv, trunc, sat));
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         t;
        rst = 1'b0;
        drive_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive_in(1, 1'b0, 8'd0, 8'd0, 1'b0);
        #2 rst = 1'b1;
        #10;
        chk("rst_p0", 32'(p0), 32'd0);
        chk("rst_flags0", {28'd0, bz0, dn0, 2'd0}, 32'd0);
        chk("rst_pair0", 32'({ma0, mb0}), 32'd0);
        chk("rst_p1", 32'(p1), 32'd0);
        chk("rst_flags1", {28'd0, bz1, dn1, 2'd0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 8'd200, 8'd150, 1'b0, 1'b0, "d200x150");
        run_op(0, 8'd255, 8'd255, 1'b0, 1'b0, "dff");
        run_op(0, 8'd0,   8'hAB,  1'b0, 1'b0, "b2b_zero");
        run_op(1, 8'h0F,  8'h0F,  1'b0, 1'b0, "tr0f");
        run_op(1, 8'h12,  8'h34,  1'b0, 1'b0, "tr1234");
        run_op(0, 8'h77,  8'h99,  1'b1, 1'b0, "sat_full");
        run_op(1, 8'h01,  8'h01,  1'b1, 1'b0, "sat_trunc");
        run_op(0, 8'h5A,  8'hC3,  1'b0, 1'b1, "poke");

        // Asynchronous reset in the middle of a cycle during step 2.
        drive_in(0, 1'b1, 8'd200, 8'd150, 1'b0);
        @(posedge clk);
        #1 drive_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_p", 32'(p0), 32'd0);
        chk("arst_busy", 32'(bz0), 32'd0);
        chk("arst_done", 32'(dn0), 32'd0);
        chk("arst_pair", 32'({ma0, mb0}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_idle_busy", 32'(bz0), 32'd0);
        run_op(0, 8'd3, 8'd5, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            t  = int'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(t, ra, rb, ($urandom_range(0, 7) == 0), 1'b0, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
